// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared constants for the seven-segment receive path.
//   - Standard digit glyphs 0..9, the three alternate glyphs (6, 7, 9) and
//     the blank pattern, all as seg[6:0] = {a,b,c,d,e,f,g}, active-high.
//   - FSM state encoding for the stability tracker.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;

    // Alternate glyphs: 6 without a, 7 with f, 9 without d.
    localparam logic [6:0] SEG_ALT_6 = 7'h1F;
    localparam logic [6:0] SEG_ALT_7 = 7'h72;
    localparam logic [6:0] SEG_ALT_9 = 7'h73;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic {
        TRACK  = 1'b0,
        LOCKED = 1'b1
    } state_e;

endpackage

// File: rtl/seg_pattern_lookup.sv
// seg_pattern_lookup: combinational classifier for one seven-segment pattern.
//   seg_i      [6:0] pattern, seg_i[6]=a ... seg_i[0]=g
//   is_digit_o       pattern is a legal digit glyph
//   is_blank_o       pattern is all segments off
//   digit_o    [3:0] decoded digit (0 when not a digit)
// Macro SEVEN_SEG_ALT_GLYPH_EN: when defined, the alternate 6/7/9 glyphs are
// also recognised as digits; otherwise they fall through as illegal.
module seg_pattern_lookup
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       is_digit_o,
    output logic       is_blank_o,
    output logic [3:0] digit_o
);

    always_comb begin
        is_digit_o = 1'b1;
        is_blank_o = 1'b0;
        digit_o    = 4'd0;
        case (seg_i)
            SEG_0:     digit_o = 4'd0;
            SEG_1:     digit_o = 4'd1;
            SEG_2:     digit_o = 4'd2;
            SEG_3:     digit_o = 4'd3;
            SEG_4:     digit_o = 4'd4;
            SEG_5:     digit_o = 4'd5;
            SEG_6:     digit_o = 4'd6;
            SEG_7:     digit_o = 4'd7;
            SEG_8:     digit_o = 4'd8;
            SEG_9:     digit_o = 4'd9;
`ifdef SEVEN_SEG_ALT_GLYPH_EN
            SEG_ALT_6: digit_o = 4'd6;
            SEG_ALT_7: digit_o = 4'd7;
            SEG_ALT_9: digit_o = 4'd9;
`endif
            SEG_BLANK: begin
                is_digit_o = 1'b0;
                is_blank_o = 1'b1;
            end
            default:   is_digit_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_segment_encoder.sv
// seven_segment_encoder: recovers a BCD digit from a sampled segment bus.
// A pattern is accepted only after it has been held STABLE_CYCLES clocks;
// shorter excursions leave the outputs untouched.
//   clk     rising-edge clock
//   reset   synchronous, active-high
//   seg     [6:0] segment pattern, seg[6]=a ... seg[0]=g
//   bcd     [3:0] last accepted digit
//   valid   stable pattern is a legal digit
//   blank   stable pattern is all-off
//   err     stable pattern is neither a digit nor blank
//   update  one-cycle pulse when an accepted pattern differs from the last one
// Macro SEVEN_SEG_ALT_GLYPH_EN (via seg_pattern_lookup) enables alt 6/7/9.
module seven_segment_encoder
    import seven_seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg,
    output logic [3:0] bcd,
    output logic       valid,
    output logic       blank,
    output logic       err,
    output logic       update
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOCK = CNT_W'(STABLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [6:0]       seg_q;
    logic [6:0]       last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bcd_q, bcd_d;
    logic             valid_q, valid_d;
    logic             blank_q, blank_d;
    logic             err_q, err_d;
    logic             update_q, update_d;

    logic             seg_chg;
    logic             is_digit, is_blank;
    logic [3:0]       digit;

    // The candidate is seg_q; on the accepting edge seg == seg_q anyway.
    seg_pattern_lookup u_lookup (
        .seg_i      (seg_q),
        .is_digit_o (is_digit),
        .is_blank_o (is_blank),
        .digit_o    (digit)
    );

    assign seg_chg = (seg != seg_q);

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        bcd_d    = bcd_q;
        valid_d  = valid_q;
        blank_d  = blank_q;
        err_d    = err_q;
        update_d = 1'b0;

        if (seg_chg)
            cnt_d = '0;
        else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + 1'b1;
        else
            cnt_d = cnt_q;

        case (state_q)
            TRACK: begin
                if (!seg_chg && cnt_q >= CNT_LOCK) begin
                    state_d  = LOCKED;
                    last_d   = seg_q;
                    update_d = (seg_q != last_q);
                    if (is_digit) begin
                        bcd_d   = digit;
                        valid_d = 1'b1;
                        blank_d = 1'b0;
                        err_d   = 1'b0;
                    end else if (is_blank) begin
                        valid_d = 1'b0;
                        blank_d = 1'b1;
                        err_d   = 1'b0;
                    end else begin
                        valid_d = 1'b0;
                        blank_d = 1'b0;
                        err_d   = 1'b1;
                    end
                end
            end
            LOCKED: begin
                // Outputs keep the previous decision until a new one lands.
                if (seg_chg)
                    state_d = TRACK;
            end
            default: state_d = TRACK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= TRACK;
            seg_q    <= SEG_BLANK;
            last_q   <= SEG_BLANK;
            cnt_q    <= '0;
            bcd_q    <= 4'd0;
            valid_q  <= 1'b0;
            blank_q  <= 1'b1;
            err_q    <= 1'b0;
            update_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            seg_q    <= seg;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            bcd_q    <= bcd_d;
            valid_q  <= valid_d;
            blank_q  <= blank_d;
            err_q    <= err_d;
            update_q <= update_d;
        end
    end

    assign bcd    = bcd_q;
    assign valid  = valid_q;
    assign blank  = blank_q;
    assign err    = err_q;
    assign update = update_q;

endmodule
